// File: rtl/vga_pixel_timing.sv
// Purpose: raster timing stage for the VGA shader pipeline; pixel strobe, counters, syncs, active flag, normalized x/y, frame counter.
// Latency: all outputs are registers that change together in the first clock of each pixel period (pix_valid high).
// Backpressure: none; free-running, the shader stage samples every output whenever pix_valid is high.
module vga_pixel_timing #(
    parameter int CLK_DIV         = 3,
    parameter int H_ACTIVE        = 800,
    parameter int H_FP            = 40,
    parameter int H_SYNC          = 128,
    parameter int H_BP            = 88,
    parameter int V_ACTIVE        = 600,
    parameter int V_FP            = 1,
    parameter int V_SYNC          = 4,
    parameter int V_BP            = 23,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int NORM_SPAN       = 2000,
    parameter int COORD_W         = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      pix_valid,
    output logic [10:0]               hcount,
    output logic [10:0]               vcount,
    output logic                      active,
    output logic                      hsync,
    output logic                      vsync,
    output logic signed [COORD_W-1:0] x_norm,
    output logic signed [COORD_W-1:0] y_norm,
    output logic                      frame_start,
    output logic [7:0]                frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);
    // Error accumulators hold values below the active width (<= 2047) and their sum with the remainder.
    localparam int ERR_W   = 12;

    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_pixel_timing: CLK_DIV must be at least 2");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_pixel_timing: raster totals must fit 11-bit counters");
    end
    if (NORM_SPAN / 2 > (2 ** (COORD_W - 1)) - 1) begin : g_bad_span
        $error("vga_pixel_timing: NORM_SPAN/2 does not fit the signed coordinate width");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [10:0]      H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0]      H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0]      V_ACT    = 11'(V_ACTIVE);

    // Sync window bounds are 12 bits so an end bound of exactly 2048 still compares correctly.
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    // Coordinate stepping: integer part of span/active per step, remainder fed to an error term.
    localparam logic signed [COORD_W-1:0] COORD_MIN = COORD_W'(-(NORM_SPAN / 2));
    localparam logic signed [COORD_W-1:0] X_SI      = COORD_W'(NORM_SPAN / H_ACTIVE);
    localparam logic signed [COORD_W-1:0] X_SI1     = COORD_W'(NORM_SPAN / H_ACTIVE + 1);
    localparam logic [ERR_W-1:0]          X_SR      = ERR_W'(NORM_SPAN % H_ACTIVE);
    localparam logic [ERR_W-1:0]          X_DEN     = ERR_W'(H_ACTIVE);
    localparam logic signed [COORD_W-1:0] Y_SI      = COORD_W'(NORM_SPAN / V_ACTIVE);
    localparam logic signed [COORD_W-1:0] Y_SI1     = COORD_W'(NORM_SPAN / V_ACTIVE + 1);
    localparam logic [ERR_W-1:0]          Y_SR      = ERR_W'(NORM_SPAN % V_ACTIVE);
    localparam logic [ERR_W-1:0]          Y_DEN     = ERR_W'(V_ACTIVE);

    logic [DIV_W-1:0]          div;
    logic [ERR_W-1:0]          x_err;
    logic [ERR_W-1:0]          y_err;

    logic                      line_wrap;
    logic                      frame_wrap;
    logic [10:0]               h_nxt;
    logic [10:0]               v_nxt;
    logic [ERR_W-1:0]          x_sum;
    logic [ERR_W-1:0]          y_sum;
    logic [ERR_W-1:0]          x_err_nxt;
    logic [ERR_W-1:0]          y_err_nxt;
    logic signed [COORD_W-1:0] x_nxt;
    logic signed [COORD_W-1:0] y_nxt;
    logic                      hs_on;
    logic                      vs_on;
    logic                      act_nxt;

    // Next-pixel values: every output is derived from the same (h_nxt, v_nxt) so they stay coherent.
    always_comb begin
        line_wrap  = (hcount == H_LAST);
        frame_wrap = line_wrap && (vcount == V_LAST);
        h_nxt      = line_wrap ? 11'd0 : hcount + 11'd1;
        v_nxt      = vcount;
        if (line_wrap) begin
            v_nxt = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
        end

        // Horizontal coordinate: restart at line start, step through active, hold through blanking.
        x_sum     = x_err + X_SR;
        x_nxt     = x_norm;
        x_err_nxt = x_err;
        if (h_nxt == 11'd0) begin
            x_nxt     = COORD_MIN;
            x_err_nxt = '0;
        end else if (h_nxt < H_ACT) begin
            if (x_sum >= X_DEN) begin
                x_nxt     = x_norm + X_SI1;
                x_err_nxt = x_sum - X_DEN;
            end else begin
                x_nxt     = x_norm + X_SI;
                x_err_nxt = x_sum;
            end
        end

        // Vertical coordinate: same scheme, but only moves when a new line begins.
        y_sum     = y_err + Y_SR;
        y_nxt     = y_norm;
        y_err_nxt = y_err;
        if (line_wrap) begin
            if (v_nxt == 11'd0) begin
                y_nxt     = COORD_MIN;
                y_err_nxt = '0;
            end else if (v_nxt < V_ACT) begin
                if (y_sum >= Y_DEN) begin
                    y_nxt     = y_norm + Y_SI1;
                    y_err_nxt = y_sum - Y_DEN;
                end else begin
                    y_nxt     = y_norm + Y_SI;
                    y_err_nxt = y_sum;
                end
            end
        end

        hs_on   = ({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END);
        vs_on   = ({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END);
        act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    end

    // Divider and raster state: everything advances together on the last clock of a pixel period.
    always_ff @(posedge clock) begin
        if (reset) begin
            div         <= '0;
            pix_valid   <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            active      <= 1'b1;
            hsync       <= SYNC_ACTIVE_LOW;
            vsync       <= SYNC_ACTIVE_LOW;
            x_norm      <= COORD_MIN;
            y_norm      <= COORD_MIN;
            x_err       <= '0;
            y_err       <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else if (div == DIV_LAST) begin
            div         <= '0;
            pix_valid   <= 1'b1;
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            active      <= act_nxt;
            hsync       <= hs_on ^ SYNC_ACTIVE_LOW;
            vsync       <= vs_on ^ SYNC_ACTIVE_LOW;
            x_norm      <= x_nxt;
            y_norm      <= y_nxt;
            x_err       <= x_err_nxt;
            y_err       <= y_err_nxt;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end else begin
            div         <= div + DIV_ONE;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Bench for vga_pixel_timing: a full-size instance for line-level behaviour and a
// miniature instance (tiny raster, CLK_DIV=2, active-high syncs) for frame-level behaviour.
// Expected outputs come from a closed-form model of the clock count since reset release.
`timescale 1ns/1ps
module tb_vga_pixel_timing;

    localparam int SPAN  = 2000;
    localparam int B_DIV = 3;
    localparam int B_HA  = 800;
    localparam int B_HFP = 40;
    localparam int B_HS  = 128;
    localparam int B_HBP = 88;
    localparam int B_VA  = 600;
    localparam int B_VFP = 1;
    localparam int B_VS  = 4;
    localparam int B_VBP = 23;
    localparam int B_HT  = B_HA + B_HFP + B_HS + B_HBP;

    localparam int S_DIV = 2;
    localparam int S_HA  = 6;
    localparam int S_HFP = 1;
    localparam int S_HS  = 1;
    localparam int S_HBP = 1;
    localparam int S_VA  = 3;
    localparam int S_VFP = 1;
    localparam int S_VS  = 1;
    localparam int S_VBP = 1;
    localparam int S_FRAME = S_DIV * (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP);

    typedef struct packed {
        logic               pv;
        logic [10:0]        h;
        logic [10:0]        v;
        logic               act;
        logic               hs;
        logic               vs;
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic               fs;
        logic [7:0]         fc;
    } obs_t;

    logic clock = 1'b0;
    logic reset_b;
    logic reset_s;
    always #5 clock = ~clock;

    logic               b_pv, b_act, b_hs, b_vs, b_fs;
    logic [10:0]        b_h, b_v;
    logic signed [11:0] b_x, b_y;
    logic [7:0]         b_fc;
    logic               s_pv, s_act, s_hs, s_vs, s_fs;
    logic [10:0]        s_h, s_v;
    logic signed [11:0] s_x, s_y;
    logic [7:0]         s_fc;

    vga_pixel_timing #(
        .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .SYNC_ACTIVE_LOW(1'b1), .NORM_SPAN(SPAN), .COORD_W(12)
    ) u_big (
        .clock(clock), .reset(reset_b), .pix_valid(b_pv), .hcount(b_h), .vcount(b_v),
        .active(b_act), .hsync(b_hs), .vsync(b_vs), .x_norm(b_x), .y_norm(b_y),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_pixel_timing #(
        .CLK_DIV(S_DIV), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .SYNC_ACTIVE_LOW(1'b0), .NORM_SPAN(SPAN), .COORD_W(12)
    ) u_small (
        .clock(clock), .reset(reset_s), .pix_valid(s_pv), .hcount(s_h), .vcount(s_v),
        .active(s_act), .hsync(s_hs), .vsync(s_vs), .x_norm(s_x), .y_norm(s_y),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    int checks = 0;
    int errors = 0;
    int nb = 0;
    int ns = 0;

    // Hand-computed values at notable horizontal positions of the full-size raster.
    int                 line_h  [10] = '{0, 1, 2, 799, 800, 839, 840, 967, 968, 1055};
    logic signed [11:0] line_x  [10] = '{-1000, -998, -995, 997, 997, 997, 997, 997, 997, 997};
    bit                 line_hs [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    bit                 line_act[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

    // Hand-computed values for the miniature raster (span 2000 over 6 columns / 3 rows).
    logic signed [11:0] s_x_tbl [9] = '{-1000, -667, -334, 0, 333, 666, 666, 666, 666};
    logic signed [11:0] s_y_tbl [6] = '{-1000, -334, 333, 333, 333, 333};
    bit                 s_hs_tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit                 s_vs_tbl[6] = '{0, 0, 0, 0, 1, 0};

    // Outputs n clocks after reset release: pixel index p = n / cdiv, raster position by modulo.
    function automatic obs_t model(int n, int cdiv, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp, int span, bit low);
        obs_t o;
        int ht, vt, p, h, v, hc, vc;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        p  = n / cdiv;
        h  = p % ht;
        v  = (p / ht) % vt;
        hc = (h < ha) ? h : ha - 1;
        vc = (v < va) ? v : va - 1;
        o.pv  = (n > 0) && (n % cdiv == 0);
        o.h   = 11'(h);
        o.v   = 11'(v);
        o.act = (h < ha) && (v < va);
        o.hs  = ((h >= ha + hfp) && (h < ha + hfp + hsw)) ^ low;
        o.vs  = ((v >= va + vfp) && (v < va + vfp + vsw)) ^ low;
        o.x   = 12'((hc * span) / ha - span / 2);
        o.y   = 12'((vc * span) / va - span / 2);
        o.fs  = o.pv && (h == 0) && (v == 0);
        o.fc  = 8'((p / (ht * vt)) % 256);
        return o;
    endfunction

    function automatic obs_t exp_b(int n);
        return model(n, B_DIV, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, SPAN, 1'b1);
    endfunction

    function automatic obs_t exp_s(int n);
        return model(n, S_DIV, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, SPAN, 1'b0);
    endfunction

    function automatic obs_t got_b();
        obs_t o;
        o = {b_pv, b_h, b_v, b_act, b_hs, b_vs, b_x, b_y, b_fs, b_fc};
        return o;
    endfunction

    function automatic obs_t got_s();
        obs_t o;
        o = {s_pv, s_h, s_v, s_act, s_hs, s_vs, s_x, s_y, s_fs, s_fc};
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pv=%0d h=%0d v=%0d act=%0d hs=%0d vs=%0d x=%0d y=%0d fs=%0d fc=%0d",
                         o.pv, o.h, o.v, o.act, o.hs, o.vs, $signed(o.x), $signed(o.y), o.fs, o.fc);
    endfunction

    task automatic test_reset();
        obs_t e, g;
        int first;
        reset_b = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        g = got_b();
        e = exp_b(0);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_state got{%s} exp{%s}", fmt(g), fmt(e));
        end
        checks++;
        if (g.pv !== 1'b0 || g.h !== 11'd0 || g.x !== -12'sd1000 || g.hs !== 1'b1 || g.act !== 1'b1) begin
            errors++;
            $display("FAIL reset_literals got{%s} exp pv=0 h=0 x=-1000 hs=1 act=1", fmt(g));
        end
        reset_b = 1'b0;
        nb = 0;
        first = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            #1;
            nb++;
            g = got_b();
            e = exp_b(nb);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL release_walk n=%0d got{%s} exp{%s}", nb, fmt(g), fmt(e));
            end
            if (g.pv && first < 0) first = nb;
            if (nb == 3) begin
                checks++;
                if (g.pv !== 1'b1 || g.h !== 11'd1 || g.x !== -12'sd998) begin
                    errors++;
                    $display("FAIL first_pixel got{%s} exp pv=1 h=1 x=-998", fmt(g));
                end
            end
        end
        checks++;
        if (first !== 3) begin
            errors++;
            $display("FAIL first_pv_clock got=%0d exp=3", first);
        end
    endtask

    task automatic test_line_walk();
        obs_t e, g;
        while (nb < B_DIV * (B_HT + 4)) begin
            @(posedge clock);
            #1;
            nb++;
            g = got_b();
            e = exp_b(nb);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL line_walk n=%0d got{%s} exp{%s}", nb, fmt(g), fmt(e));
            end
            if (e.pv) begin
                for (int i = 0; i < 10; i++) begin
                    if (int'(e.h) == line_h[i]) begin
                        checks++;
                        if (g.x !== line_x[i] || g.hs !== line_hs[i] || g.act !== line_act[i]) begin
                            errors++;
                            $display("FAIL line_point h=%0d got x=%0d hs=%0d act=%0d exp x=%0d hs=%0d act=%0d",
                                     line_h[i], $signed(g.x), g.hs, g.act, $signed(line_x[i]), line_hs[i], line_act[i]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_frame_walk();
        obs_t e, g;
        int fs_cnt;
        reset_s = 1'b1;
        @(posedge clock);
        #1;
        g = got_s();
        checks++;
        if (g !== exp_s(0) || g.hs !== 1'b0 || g.vs !== 1'b0 || g.y !== -12'sd1000) begin
            errors++;
            $display("FAIL small_reset got{%s} exp{%s}", fmt(g), fmt(exp_s(0)));
        end
        reset_s = 1'b0;
        ns = 0;
        fs_cnt = 0;
        while (ns < 2 * S_FRAME + 30) begin
            @(posedge clock);
            #1;
            ns++;
            g = got_s();
            e = exp_s(ns);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL frame_walk n=%0d got{%s} exp{%s}", ns, fmt(g), fmt(e));
            end
            if (e.pv) begin
                checks++;
                if (g.x !== s_x_tbl[e.h] || g.y !== s_y_tbl[e.v] || g.hs !== s_hs_tbl[e.h] || g.vs !== s_vs_tbl[e.v]) begin
                    errors++;
                    $display("FAIL small_point h=%0d v=%0d got x=%0d y=%0d hs=%0d vs=%0d exp x=%0d y=%0d hs=%0d vs=%0d",
                             e.h, e.v, $signed(g.x), $signed(g.y), g.hs, g.vs,
                             $signed(s_x_tbl[e.h]), $signed(s_y_tbl[e.v]), s_hs_tbl[e.h], s_vs_tbl[e.v]);
                end
            end
            if (g.fs) begin
                fs_cnt++;
                if (fs_cnt == 1) begin
                    checks++;
                    if (g.fc !== 8'd1 || g.h !== 11'd0 || g.v !== 11'd0 || g.pv !== 1'b1) begin
                        errors++;
                        $display("FAIL first_frame_start got{%s} exp pv=1 h=0 v=0 fc=1", fmt(g));
                    end
                end
            end
        end
        checks++;
        if (fs_cnt !== 2) begin
            errors++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        end
    endtask

    task automatic test_frame_wrap();
        obs_t e, g;
        int   ns0, fs_cnt, exp_cnt;
        bit   saw_wrap;
        logic [7:0] prev_fc;
        ns0      = ns;
        fs_cnt   = 0;
        saw_wrap = 1'b0;
        prev_fc  = s_fc;
        while (ns < 257 * S_FRAME + 5) begin
            @(posedge clock);
            #1;
            ns++;
            g = got_s();
            e = exp_s(ns);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL frame_wrap n=%0d got{%s} exp{%s}", ns, fmt(g), fmt(e));
            end
            if (g.fs) fs_cnt++;
            if (prev_fc == 8'd255 && g.fc == 8'd0) saw_wrap = 1'b1;
            prev_fc = g.fc;
        end
        exp_cnt = ns / S_FRAME - ns0 / S_FRAME;
        checks++;
        if (fs_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL wrap_frame_starts got=%0d exp=%0d", fs_cnt, exp_cnt);
        end
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL frame_count_255_to_0 got=%0d exp=1", saw_wrap);
        end
    endtask

    task automatic test_mid_reset_small();
        obs_t e, g;
        int   len, hold;
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(3, 400));
            for (int k = 0; k < len; k++) begin
                @(posedge clock);
                #1;
                ns++;
                g = got_s();
                e = exp_s(ns);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL pre_reset n=%0d got{%s} exp{%s}", ns, fmt(g), fmt(e));
                end
            end
            reset_s = 1'b1;
            hold = int'($urandom_range(1, 3));
            for (int k = 0; k < hold; k++) begin
                @(posedge clock);
                #1;
                g = got_s();
                e = exp_s(0);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL reset_hold got{%s} exp{%s}", fmt(g), fmt(e));
                end
            end
            reset_s = 1'b0;
            ns = 0;
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            ns++;
            g = got_s();
            e = exp_s(ns);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL resume n=%0d got{%s} exp{%s}", ns, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_mid_reset_line();
        obs_t e, g;
        int   extra;
        reset_b = 1'b1;
        @(posedge clock);
        #1;
        reset_b = 1'b0;
        nb = 0;
        e = exp_b(0);
        g = got_b();
        while (!(e.pv && e.h == 11'd500)) begin
            @(posedge clock);
            #1;
            nb++;
            g = got_b();
            e = exp_b(nb);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL walk_to_500 n=%0d got{%s} exp{%s}", nb, fmt(g), fmt(e));
            end
        end
        extra = int'($urandom_range(0, B_DIV - 1));
        for (int k = 0; k < extra; k++) begin
            @(posedge clock);
            #1;
            nb++;
        end
        g = got_b();
        checks++;
        if (g.h !== 11'd500 || g.x !== 12'sd250) begin
            errors++;
            $display("FAIL at_500 got h=%0d x=%0d exp h=500 x=250", g.h, $signed(g.x));
        end
        reset_b = 1'b1;
        @(posedge clock);
        #1;
        g = got_b();
        e = exp_b(0);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_line_reset got{%s} exp{%s}", fmt(g), fmt(e));
        end
        reset_b = 1'b0;
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            #1;
            nb++;
            g = got_b();
            e = exp_b(nb);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL post_reset n=%0d got{%s} exp{%s}", nb, fmt(g), fmt(e));
            end
        end
    endtask

    initial begin
        reset_b = 1'b1;
        reset_s = 1'b1;
        test_reset();
        test_line_walk();
        test_frame_walk();
        test_frame_wrap();
        test_mid_reset_small();
        test_mid_reset_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
